// File: rtl/fir_pkg.sv
// Shared definitions for the FIR transmit back end: word-format defaults,
// rounding constant helper, Q1.15 limits and serializer state encoding.
package fir_pkg;

  localparam int unsigned OUT_W_DEF      = 16;
  localparam int unsigned FRAC_SHIFT_DEF = 15;

  localparam logic [OUT_W_DEF-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [OUT_W_DEF-1:0] Q15_MIN = 16'h8000;

  // Half an output LSB expressed in input LSBs (round-half-up before the shift).
  function automatic longint unsigned round_const(input int unsigned frac_shift);
    return (frac_shift == 0) ? 64'd0 : (64'd1 << (frac_shift - 1));
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } ser_state_e;

endpackage

// File: rtl/fir_sample_serializer_if.sv
// Sample input and framed serial link of the FIR transmit back end.
interface fir_sample_serializer_if #(
  parameter int unsigned IN_W = 32
);
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            ser_data;
  logic            ser_frame;
  logic            ser_busy;

  modport master (output in_valid, output in_data,
                  input  ser_data, input  ser_frame, input ser_busy);
  modport slave  (input  in_valid, input  in_data,
                  output ser_data, output ser_frame, output ser_busy);
endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_serializer.sv
// Requantizes Q2.30 FIR samples to Q1.15, buffers them and shifts them out
// MSB-first on a framed serial link. Define FIR_SAT_EN for saturation.
module fir_sample_serializer
  import fir_pkg::*;
#(
  parameter int unsigned IN_W       = 32,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIT_DIV    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  fir_sample_serializer_if.slave      bus,
  output logic                        sat_flag,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned BW = $clog2(OUT_W);
  localparam int unsigned DW = $clog2(BIT_DIV + 1);
  localparam logic [IN_W:0] RND = (IN_W + 1)'(round_const(FRAC_SHIFT));

  logic signed [IN_W:0] sum;
  logic [OUT_W-1:0]     word_d;
  logic [OUT_W-1:0]     word_q;
  logic                 word_vld;

  assign sum = {bus.in_data[IN_W-1], bus.in_data} + RND;

`ifdef FIR_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX =
    (OUT_W == OUT_W_DEF) ? OUT_W'(Q15_MAX) : {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN =
    (OUT_W == OUT_W_DEF) ? OUT_W'(Q15_MIN) : {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] r;
  logic                 clip;

  // In range only when every bit above the output sign bit matches it.
  assign r      = sum >>> FRAC_SHIFT;
  assign clip   = !((r[IN_W:OUT_W-1] == '0) || (r[IN_W:OUT_W-1] == '1));
  assign word_d = clip ? (r[IN_W] ? SAT_MIN : SAT_MAX) : r[OUT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_flag <= 1'b0;
    else        sat_flag <= bus.in_valid && clip;
  end
`else
  assign word_d   = OUT_W'(sum >>> FRAC_SHIFT);
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_vld <= 1'b0;
      word_q   <= '0;
    end else begin
      word_vld <= bus.in_valid;
      if (bus.in_valid) word_q <= word_d;
    end
  end

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_head;
  logic             drop;

  sample_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_vld),
    .pop   (fifo_pop),
    .wdata (word_q),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign drop = word_vld && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  ser_state_e       state;
  ser_state_e       state_d;
  logic [OUT_W-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             bit_end;
  logic             last_bit;

  assign bit_end  = (div_cnt == DW'(BIT_DIV - 1));
  assign last_bit = (bit_cnt == BW'(OUT_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    fifo_pop = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        fifo_pop = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT:   if (bit_end && last_bit) state_d = GAP;
      GAP:     if (bit_end) state_d = fifo_empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= fifo_head;
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[OUT_W-2:0], 1'b0};
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        GAP:     div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
        default: div_cnt <= '0;
      endcase
    end
  end

  assign bus.ser_busy  = (state != IDLE);
  assign bus.ser_frame = (state == SHIFT) && (bit_cnt == '0);
  assign bus.ser_data  = (state == SHIFT) && shreg[OUT_W-1];

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Randomized self-checking bench for fir_sample_serializer against a
// behavioural requantize-and-serialize model.
`timescale 1ns/1ps
module tb_fir_sample_serializer;

  localparam int unsigned IN_W        = 32;
  localparam int unsigned OUT_W       = 16;
  localparam int unsigned FRAC_SHIFT  = 15;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned BIT_DIV     = 2;
  localparam int          WORD_PERIOD = 1 + (OUT_W + 1) * BIT_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       sat_flag;
  logic       ovf;
  logic [2:0] fifo_level;

  fir_sample_serializer_if #(.IN_W(IN_W)) bus ();

  fir_sample_serializer #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BIT_DIV    (BIT_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sat_flag   (sat_flag),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  function automatic longint rounded(input logic [31:0] x);
    longint v;
    v = longint'($signed(x)) + 64'sd16384;
    return v >>> 15;
  endfunction

  function automatic logic [15:0] model_word(input logic [31:0] x);
    longint     r;
    logic [63:0] u;
    r = rounded(x);
`ifdef FIR_SAT_EN
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
`endif
    u = r;
    return u[15:0];
  endfunction

  function automatic int model_sat(input logic [31:0] x);
`ifdef FIR_SAT_EN
    longint r;
    r = rounded(x);
    return ((r > 32767) || (r < -32768)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- serial link monitor ----------------
  bit          cap_on = 0;
  int          cap_k, cap_start, cap_fhi;
  logic [15:0] cap_word;
  logic        prev_frame = 1'b0;
  logic [15:0] rx_word[$];
  int          rx_start[$];
  int          rx_fhi[$];
  int          sat_cnt = 0;
  int          lvl_peak = 0;

  always @(negedge clk) begin
    if (!reset) begin
      cap_on     = 0;
      prev_frame = 1'b0;
    end else begin
      if (bus.ser_frame && !prev_frame) begin
        cap_on    = 1;
        cap_k     = 0;
        cap_fhi   = 0;
        cap_word  = '0;
        cap_start = cyc;
      end
      if (cap_on) begin
        if (bus.ser_frame) cap_fhi++;
        if ((cap_k % BIT_DIV) == 0) cap_word = {cap_word[14:0], bus.ser_data};
        cap_k++;
        if (cap_k == OUT_W * BIT_DIV) begin
          rx_word.push_back(cap_word);
          rx_start.push_back(cap_start);
          rx_fhi.push_back(cap_fhi);
          cap_on = 0;
        end
      end
      if (sat_flag) sat_cnt++;
      if (int'(fifo_level) > lvl_peak) lvl_peak = int'(fifo_level);
      prev_frame = bus.ser_frame;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_one(input logic [31:0] x, output int n);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    n = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.ser_busy && fifo_level == 0 && !cap_on) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ser_data !== 1'b0)  begin n_fail++; $display("FAIL rst_ser_data: got %b expected 0", bus.ser_data); end
    n_checks++; if (bus.ser_frame !== 1'b0) begin n_fail++; $display("FAIL rst_ser_frame: got %b expected 0", bus.ser_frame); end
    n_checks++; if (bus.ser_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_ser_busy: got %b expected 0", bus.ser_busy); end
    n_checks++; if (sat_flag !== 1'b0)      begin n_fail++; $display("FAIL rst_sat_flag: got %b expected 0", sat_flag); end
    n_checks++; if (ovf !== 1'b0)           begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    n_checks++; if (fifo_level !== 3'd0)    begin n_fail++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (bus.ser_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_idle_busy: got %b expected 0", bus.ser_busy); end
  endtask

  task automatic test_latency();
    int n0, base;
    bit ok;
    base = rx_word.size();
    send_one(32'h1000_0000, n0);
    wait_idle(ok);
    n_checks++;
    if (!ok || rx_word.size() != base + 1) begin
      n_fail++; $display("FAIL lat_count: got %0d words (idle=%0d) expected 1", rx_word.size() - base, ok);
    end else begin
      n_checks++; if (rx_word[base] !== 16'h2000) begin n_fail++; $display("FAIL lat_word: got %h expected 2000", rx_word[base]); end
      n_checks++; if (rx_start[base] != n0 + 4)   begin n_fail++; $display("FAIL lat_start: got edge %0d expected %0d", rx_start[base], n0 + 4); end
      n_checks++; if (rx_fhi[base] != BIT_DIV)    begin n_fail++; $display("FAIL lat_frame_len: got %0d expected %0d", rx_fhi[base], BIT_DIV); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vec [6];
    int n0, base;
    bit ok;
    vec = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF, 32'h0000_C000, 32'hFFFF_4000};
    foreach (vec[i]) begin
      base = rx_word.size();
      send_one(vec[i], n0);
      wait_idle(ok);
      n_checks++;
      if (!ok || rx_word.size() != base + 1) begin
        n_fail++; $display("FAIL round_count[%0d]: got %0d words expected 1", i, rx_word.size() - base);
      end else if (rx_word[base] !== model_word(vec[i])) begin
        n_fail++; $display("FAIL round_word[%0d]: in %h got %h expected %h", i, vec[i], rx_word[base], model_word(vec[i]));
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vec [4];
    int n0, base, s0;
    bit ok;
    vec = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h3FFF_BFFF, 32'h3FFF_C000};
    foreach (vec[i]) begin
      base = rx_word.size();
      s0   = sat_cnt;
      send_one(vec[i], n0);
      wait_idle(ok);
      n_checks++;
      if (!ok || rx_word.size() != base + 1) begin
        n_fail++; $display("FAIL sat_count[%0d]: got %0d words expected 1", i, rx_word.size() - base);
      end else if (rx_word[base] !== model_word(vec[i])) begin
        n_fail++; $display("FAIL sat_word[%0d]: in %h got %h expected %h", i, vec[i], rx_word[base], model_word(vec[i]));
      end
      n_checks++;
      if (sat_cnt - s0 != model_sat(vec[i])) begin
        n_fail++; $display("FAIL sat_pulse[%0d]: got %0d pulse cycles expected %0d", i, sat_cnt - s0, model_sat(vec[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] r;
    logic [15:0] exp_q[$];
    int n0, base, s0, exp_sat;
    bit ok;
    base = rx_word.size();
    s0 = sat_cnt;
    exp_sat = 0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       x = r;
        1:       x = {{3{r[31]}}, r[28:0]};
        default: x = 32'h3FFF_C000 + 32'($urandom_range(0, 65535)) - 32'd32768;
      endcase
      exp_q.push_back(model_word(x));
      exp_sat += model_sat(x);
      send_one(x, n0);
      repeat (WORD_PERIOD) @(negedge clk);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || rx_word.size() != base + 16) begin
      n_fail++; $display("FAIL rand_count: got %0d words expected 16", rx_word.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (rx_word[base + i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", i, rx_word[base + i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (sat_cnt - s0 != exp_sat) begin
      n_fail++; $display("FAIL rand_sat: got %0d pulses expected %0d", sat_cnt - s0, exp_sat);
    end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rand_no_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [6];
    int n0, base;
    bit ok;
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    for (int i = 0; i < 6; i++) vec[i] = {{2{1'b0}}, 30'($urandom)} - 32'h2000_0000;
    base = rx_word.size();
    lvl_peak = 0;
    @(negedge clk);
    n0 = cyc;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      @(negedge clk);
    end
    // the sixth word reaches the full FIFO at edge n0+7; clear requested there too
    bus.in_valid = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf_prio: got %b expected 1 at edge %0d", ovf, cyc); end
    wait_idle(ok);
    n_checks++;
    if (!ok || rx_word.size() != base + 5) begin
      n_fail++; $display("FAIL b2b_count: got %0d words expected 5", rx_word.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (rx_word[base + i] !== model_word(vec[i])) begin
          n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, rx_word[base + i], model_word(vec[i]));
        end
        if (i > 0) begin
          n_checks++;
          if (rx_start[base + i] - rx_start[base + i - 1] != WORD_PERIOD) begin
            n_fail++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, rx_start[base + i] - rx_start[base + i - 1], WORD_PERIOD);
          end
        end
      end
      n_checks++;
      if (rx_start[base] != n0 + 4) begin n_fail++; $display("FAIL b2b_first: got %0d expected %0d", rx_start[base], n0 + 4); end
    end
    n_checks++;
    if (lvl_peak != FIFO_DEPTH) begin n_fail++; $display("FAIL b2b_level_peak: got %0d expected %0d", lvl_peak, FIFO_DEPTH); end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf_sticky: got %b expected 1", ovf); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_clr: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] x;
    logic [15:0] w;
    int n0, base, s;
    bit found, busy_seen, ok;
    x = 32'h2AAA_8000;
    w = model_word(x);
    send_one(x, n0);
    found = 0;
    s = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ser_frame) begin found = 1; s = cyc; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL mid_frame_start: got no frame expected frame within 20 cycles");
    end else begin
      repeat (7 * BIT_DIV) @(negedge clk);
      n_checks++;
      if (bus.ser_data !== w[OUT_W - 1 - 7]) begin
        n_fail++; $display("FAIL mid_bit7: got %b expected %b at edge %0d", bus.ser_data, w[OUT_W - 1 - 7], cyc - s);
      end
      #1 reset = 1'b0;
      #1;
      n_checks++; if (bus.ser_data !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_data: got %b expected 0", bus.ser_data); end
      n_checks++; if (bus.ser_frame !== 1'b0) begin n_fail++; $display("FAIL mid_rst_frame: got %b expected 0", bus.ser_frame); end
      n_checks++; if (bus.ser_busy !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", bus.ser_busy); end
      n_checks++; if (fifo_level !== 3'd0)    begin n_fail++; $display("FAIL mid_rst_level: got %0d expected 0", fifo_level); end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = rx_word.size();
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.ser_busy) busy_seen = 1;
    end
    n_checks++;
    if (busy_seen || rx_word.size() != base) begin
      n_fail++; $display("FAIL mid_quiet: got busy=%0d words=%0d expected busy=0 words=0", busy_seen, rx_word.size() - base);
    end
    send_one(32'h1000_0000, n0);
    wait_idle(ok);
    n_checks++;
    if (!ok || rx_word.size() != base + 1) begin
      n_fail++; $display("FAIL mid_resume_count: got %0d words expected 1", rx_word.size() - base);
    end else if (rx_word[base] !== 16'h2000) begin
      n_fail++; $display("FAIL mid_resume_word: got %h expected 2000", rx_word[base]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
